// File: rtl/encout_pkg.sv
// Shared constants for the encoder-emulation output generator.
package encout_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   localparam logic [1:0] ENC_QUAD    = 2'b00;
   localparam logic [1:0] ENC_STEPDIR = 2'b01;
   localparam logic [1:0] ENC_CWCCW   = 2'b10;

   localparam logic [2:0] ZW_MAX = 3'd4;

   // Gray-style A/B decode of the two position LSBs: 00->10, 01->00, 10->01, 11->11
   function automatic logic [1:0] quad_ab(input logic [1:0] p);
      return {~(p[1] ^ p[0]), p[1]};
   endfunction

endpackage

// File: rtl/encout_cmd_fifo.sv
// Command FIFO: synchronous, flushable, with registered level and look-ahead level.
module encout_cmd_fifo #(
   parameter int unsigned CW    = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       i_pclk,
   input  logic                       i_prst,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [CW-1:0]              i_data,
   input  logic                       i_pop,
   output logic [CW-1:0]              o_data_c,
   output logic [$clog2(DEPTH+1)-1:0] o_level,
   output logic [$clog2(DEPTH+1)-1:0] o_level_nxt_c
);

   localparam int unsigned LW   = $clog2(DEPTH + 1);
   localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CW-1:0]   mem [DEPTH];
   logic [PTRW-1:0] wr_ptr;
   logic [PTRW-1:0] rd_ptr;
   logic            push_ok;
   logic            pop_ok;

   function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
      return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
   endfunction

   always_comb begin
      push_ok       = i_push && !i_flush && (o_level < LW'(DEPTH));
      pop_ok        = i_pop && !i_flush && (o_level != '0);
      o_level_nxt_c = o_level;
      if (i_flush)
         o_level_nxt_c = '0;
      else if (push_ok && !pop_ok)
         o_level_nxt_c = o_level + LW'(1);
      else if (pop_ok && !push_ok)
         o_level_nxt_c = o_level - LW'(1);
   end

   assign o_data_c = mem[rd_ptr];

   always_ff @(posedge i_pclk or posedge i_prst) begin
      if (i_prst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_level <= '0;
      end else begin
         o_level <= o_level_nxt_c;
         if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
         end
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge i_pclk) begin
      if (push_ok) mem[wr_ptr] <= i_data;
   end

endmodule

// File: rtl/encout_pulse_gen.sv
// Encoder-emulation output generator: spreads each segment's edge command over the
// programmed period with a DDA and drives A/B/Z in quadrature, step/dir or CW/CCW form.
module encout_pulse_gen
   import encout_pkg::*;
#(
   parameter int unsigned CW    = 16,
   parameter int unsigned PW    = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       i_pclk,
   input  logic                       i_prst,
   input  logic                       i_en,
   input  logic [1:0]                 i_mode,
   input  logic                       i_pol,
   input  logic [2:0]                 i_zw,
   input  logic [CW-1:0]              i_posmax,
   input  logic [PW-1:0]              i_period,
   input  logic                       i_cmd_vld,
   output logic                       o_cmd_rdy,
   input  logic [CW-1:0]              i_cmd_data,
   input  logic                       i_pos_wr,
   input  logic [CW-1:0]              i_pos_wdata,
   input  logic                       i_elcin_sync,
   output logic                       o_pouta,
   output logic                       o_poutb,
   output logic                       o_poutz,
   output logic [CW-1:0]              o_pos,
   output logic [$clog2(DEPTH+1)-1:0] o_fifo_level,
   output logic                       o_err_underrun,
   output logic                       o_err_overrun
);

   localparam int unsigned LW   = $clog2(DEPTH + 1);
   localparam int unsigned AW   = (CW > PW) ? CW + 1 : PW + 1;
   localparam int unsigned ACCW = PW + 1;

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic            sync_act;
   logic            pop_c;
   logic            underrun_c;
   logic            overrun_c;

   logic [CW-1:0]   fifo_data;
   logic [LW-1:0]   level_nxt;
   logic            fifo_flush;
   logic            fifo_push;

   logic [PW-1:0]   period_eff;
   logic [PW-1:0]   half;
   logic            is_quad;
   logic [AW-1:0]   cmd_ext;
   logic [AW-1:0]   cmd_abs;
   logic [AW-1:0]   lim;
   logic [AW-1:0]   abs_clamp;
   logic [ACCW-1:0] acc_sum;
   logic [ACCW-1:0] acc_nxt;
   logic            hit;
   logic [PW-1:0]   seg_inc;
   logic            done;
   logic            edge_c;
   logic [CW-1:0]   posmax_m1;
   logic [CW-1:0]   pos_up;
   logic [CW-1:0]   pos_dn;

   logic [PW-1:0]   abs_q;
   logic            dir_q;
   logic [ACCW-1:0] acc_q;
   logic [PW-1:0]   seg_q;
   logic            edge_q;
   logic            edge_dn_q;

   logic [2:0]      zw_eff;
   logic            z_c;
   logic [1:0]      ab_c;

   assign fifo_flush = (state_nxt == ST_IDLE);
   assign fifo_push  = i_cmd_vld && o_cmd_rdy;

   encout_cmd_fifo #(
      .CW    (CW),
      .DEPTH (DEPTH)
   ) u_cmd_fifo (
      .i_pclk        (i_pclk),
      .i_prst        (i_prst),
      .i_flush       (fifo_flush),
      .i_push        (fifo_push),
      .i_data        (i_cmd_data),
      .i_pop         (pop_c),
      .o_data_c      (fifo_data),
      .o_level       (o_fifo_level),
      .o_level_nxt_c (level_nxt)
   );

   // DDA step, command clamp and position neighbours
   always_comb begin
      period_eff = (i_period == '0) ? PW'(1) : i_period;
      half       = period_eff >> 1;
      is_quad    = (i_mode != ENC_STEPDIR) && (i_mode != ENC_CWCCW);
      cmd_ext    = {{(AW - CW){fifo_data[CW-1]}}, fifo_data};
      cmd_abs    = fifo_data[CW-1] ? (~cmd_ext + AW'(1)) : cmd_ext;
      if (is_quad)
         lim = AW'(period_eff);
      else if (half == '0)
         lim = AW'(1);
      else
         lim = AW'(half);
      abs_clamp = (cmd_abs > lim) ? lim : cmd_abs;

      acc_sum = acc_q + ACCW'(abs_q);
      hit     = (acc_sum >= ACCW'(period_eff));
      acc_nxt = hit ? (acc_sum - ACCW'(period_eff)) : acc_sum;
      seg_inc = seg_q + PW'(1);
      done    = (seg_inc == period_eff);
      edge_c  = (state == ST_RUN) && i_en && hit;

      posmax_m1 = i_posmax - CW'(1);
      pos_up    = (o_pos >= posmax_m1) ? '0 : o_pos + CW'(1);
      pos_dn    = (o_pos == '0) ? posmax_m1 : o_pos - CW'(1);
   end

   always_ff @(posedge i_pclk or posedge i_prst) begin
      if (i_prst) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Strobe handling: a completion-cycle strobe chains straight into the next segment
   always_comb begin
      state_nxt  = state;
      sync_act   = i_elcin_sync && i_en && ((state == ST_ARMED) || (state == ST_RUN));
      pop_c      = sync_act && (o_fifo_level != '0);
      underrun_c = sync_act && (o_fifo_level == '0);
      overrun_c  = sync_act && (state == ST_RUN) && !done;
      case (state)
         ST_IDLE: begin
            if (i_en) state_nxt = ST_ARMED;
         end
         ST_ARMED: begin
            if (!i_en)      state_nxt = ST_IDLE;
            else if (pop_c) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!i_en)         state_nxt = ST_IDLE;
            else if (sync_act) state_nxt = pop_c ? ST_RUN : ST_ARMED;
            else if (done)     state_nxt = ST_ARMED;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_pclk or posedge i_prst) begin
      if (i_prst) begin
         abs_q          <= '0;
         dir_q          <= 1'b0;
         acc_q          <= '0;
         seg_q          <= '0;
         o_pos          <= '0;
         edge_q         <= 1'b0;
         edge_dn_q      <= 1'b0;
         o_cmd_rdy      <= 1'b0;
         o_err_underrun <= 1'b0;
         o_err_overrun  <= 1'b0;
      end else begin
         if (pop_c) begin
            abs_q <= PW'(abs_clamp);
            dir_q <= fifo_data[CW-1];
            acc_q <= '0;
            seg_q <= '0;
         end else if (state == ST_IDLE) begin
            acc_q <= '0;
            seg_q <= '0;
         end else if (state == ST_RUN) begin
            acc_q <= acc_nxt;
            seg_q <= seg_inc;
         end

         if ((state == ST_IDLE) && i_pos_wr)
            o_pos <= i_pos_wdata;
         else if (edge_c)
            o_pos <= dir_q ? pos_dn : pos_up;

         edge_q         <= edge_c;
         edge_dn_q      <= edge_c && dir_q;
         o_cmd_rdy      <= (state_nxt != ST_IDLE) && (level_nxt < LW'(DEPTH));
         o_err_underrun <= underrun_c;
         o_err_overrun  <= overrun_c;
      end
   end

   // Pin decode from the registered position and edge flags
   always_comb begin
      zw_eff = (i_zw > ZW_MAX) ? ZW_MAX : i_zw;
      z_c    = (zw_eff != '0) && (o_pos < CW'(zw_eff));
      ab_c   = quad_ab(o_pos[1:0]);
      case (i_mode)
         ENC_STEPDIR: ab_c = {edge_q, dir_q};
         ENC_CWCCW:   ab_c = {edge_q && !edge_dn_q, edge_dn_q};
         default:     ;
      endcase
   end

   always_ff @(posedge i_pclk or posedge i_prst) begin
      if (i_prst) begin
         o_pouta <= 1'b0;
         o_poutb <= 1'b0;
         o_poutz <= 1'b0;
      end else begin
         o_pouta <= ab_c[1] ^ i_pol;
         o_poutb <= ab_c[0] ^ i_pol;
         o_poutz <= z_c ^ i_pol;
      end
   end

endmodule
